sram_axi_bridge_mp: RTL and testbench

Multi-port bridge converting NPORT SRAM-like request/response ports (req/wr/size/addr/wdata, addr_ok/data_ok) into one AXI3 master; successor of the fixed two-port inst/data adapter in the CPU top level. Independent round-robin arbiters serve the read and write paths. Multiple reads per port may be in flight, tagged by AXI ID = port index, so responses route by `rid`/`bid`. Sits between the core/cache request ports and the SoC AXI crossbar.

---
 rtl/sram_axi_bridge_mp_pkg.sv | 43 ++++
 rtl/sram_axi_bridge_mp_if.sv | 54 +++++
 rtl/sram_axi_bridge_mp_rr_arbiter.sv | 48 ++++
 rtl/sram_axi_bridge_mp.sv | 168 ++++++++++++++++
 tb/tb_sram_axi_bridge_mp.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_mp_pkg.sv
`default_nettype none
//==============================================================================
// Module      : sram_axi_bridge_mp_pkg
// Description : AXI3 encodings, SRAM-like size codes and byte-strobe helper
//               shared by the multi-port SRAM-to-AXI3 bridge.
// Revision    : 1.0 - initial release
//==============================================================================
package sram_axi_bridge_mp_pkg;

    localparam logic [1:0] c_burst_incr     = 2'b01;
    localparam logic [3:0] c_cache_uncached = 4'b0000;
    localparam logic [3:0] c_cache_cached   = 4'b1111;
    localparam logic [2:0] c_prot_default   = 3'b000;
    localparam logic [1:0] c_lock_normal    = 2'b00;
    localparam logic [3:0] c_len_single     = 4'd0;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } sram_size_e;

    // Request fields captured from the granted port
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uncached;
        logic [3:0]  id;
    } port_sel_t;

    function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            SIZE_BYTE: s = 4'b0001 << a;
            SIZE_HALF: s = 4'b0011 << a;
            default:   s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge_mp_if.sv
`default_nettype none
//==============================================================================
// Module      : sram_axi_bridge_mp_if
// Description : SRAM-like request ports plus AXI3 master channels of the bridge.
// Revision    : 1.0 - initial release
//==============================================================================
interface sram_axi_bridge_mp_if #(parameter int NPORT = 2);

    logic [NPORT-1:0]    port_req, port_wr, port_uncached;
    logic [2*NPORT-1:0]  port_size;
    logic [32*NPORT-1:0] port_addr, port_wdata;
    logic [NPORT-1:0]    port_addr_ok, port_data_ok;
    logic [32*NPORT-1:0] port_rdata;

    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, rid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    modport master (
        input  port_req, port_wr, port_uncached, port_size, port_addr, port_wdata,
        output port_addr_ok, port_data_ok, port_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output port_req, port_wr, port_uncached, port_size, port_addr, port_wdata,
        input  port_addr_ok, port_data_ok, port_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/sram_axi_bridge_mp_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, one-hot grant; pointer moves on advance.
// Revision    : 1.0 - initial release
//==============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [N-1:0] i_req,
    input  wire logic         i_advance,
    output logic      [N-1:0] o_grant
);

    localparam int c_pw = (N > 1) ? $clog2(N) : 1;

    logic [c_pw-1:0] r_last;
    logic [c_pw-1:0] w_idx;
    logic            w_found;
    int              w_cand;

    // Scan starting just after the last winner so it gets lowest priority
    always_comb begin
        o_grant = '0;
        w_idx   = r_last;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 1; i <= N; i++) begin
            w_cand = (int'(r_last) + i) % N;
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                w_idx           = c_pw'(w_cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= c_pw'(N - 1);
        else if (i_advance && w_found)
            r_last <= w_idx;
    end

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge_mp.sv
`default_nettype none
//==============================================================================
// Module      : sram_axi_bridge_mp
// Description : NPORT SRAM-like ports to one AXI3 master, ID = port index.
//               Optional: SRAM_AXI_BRIDGE_CHECKER_EN enables the bus_err checker.
// Revision    : 1.0 - initial release
//==============================================================================
module sram_axi_bridge_mp
    import sram_axi_bridge_mp_pkg::*;
#(
    parameter int NPORT       = 2,
    parameter int OUTSTANDING = 4
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    sram_axi_bridge_mp_if.master    bus,
    output logic                    bus_err
);

    logic [NPORT-1:0] w_rd_elig, w_wr_elig, w_rd_grant, w_wr_grant;
    logic [NPORT-1:0] w_r_hit, w_b_hit;
    logic             w_rd_free, w_wr_free, w_rd_go, w_wr_go;
    port_sel_t        w_rd_sel, w_wr_sel;
`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
    logic [NPORT-1:0] w_port_err;
`endif

    assign w_rd_free = !bus.arvalid || bus.arready;
    assign w_wr_free = (!bus.awvalid || bus.awready) && (!bus.wvalid || bus.wready);
    assign w_rd_go   = w_rd_free && (|w_rd_grant);
    assign w_wr_go   = w_wr_free && (|w_wr_grant);

    assign bus.port_addr_ok = (w_rd_grant & {NPORT{w_rd_free}}) | (w_wr_grant & {NPORT{w_wr_free}});
    assign bus.port_data_ok = w_r_hit | w_b_hit;
    assign bus.rready       = 1'b1;
    assign bus.bready       = 1'b1;

    rr_arbiter #(.N(NPORT)) u_rd_arb (
        .clk(aclk), .rst_n(aresetn), .i_req(w_rd_elig), .i_advance(w_rd_free), .o_grant(w_rd_grant)
    );
    rr_arbiter #(.N(NPORT)) u_wr_arb (
        .clk(aclk), .rst_n(aresetn), .i_req(w_wr_elig), .i_advance(w_wr_free), .o_grant(w_wr_grant)
    );

    // Per-port outstanding counter and direction; a port only mixes directions once idle
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [3:0] r_cnt;
        logic       r_dir;
        logic       w_ok, w_dec;

        assign w_ok  = (r_cnt < 4'(OUTSTANDING));
        assign w_rd_elig[p] = bus.port_req[p] && !bus.port_wr[p] && w_ok && (r_cnt == 4'd0 || !r_dir);
        assign w_wr_elig[p] = bus.port_req[p] &&  bus.port_wr[p] && w_ok && (r_cnt == 4'd0 ||  r_dir);
        assign w_r_hit[p]   = bus.rvalid && (bus.rid == 4'(p));
        assign w_b_hit[p]   = bus.bvalid && (bus.bid == 4'(p));
        assign w_dec        = bus.port_data_ok[p] && (r_cnt != 4'd0);
        assign bus.port_rdata[p*32 +: 32] = bus.rdata;
`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
        assign w_port_err[p] = (w_r_hit[p] && (r_cnt == 4'd0 ||  r_dir)) ||
                               (w_b_hit[p] && (r_cnt == 4'd0 || !r_dir));
`endif

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_cnt <= 4'd0;
                r_dir <= 1'b0;
            end else begin
                if (bus.port_addr_ok[p])
                    r_dir <= bus.port_wr[p];
                case ({bus.port_addr_ok[p], w_dec})
                    2'b10:   r_cnt <= r_cnt + 4'd1;
                    2'b01:   r_cnt <= r_cnt - 4'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_sel = '0;
        w_wr_sel = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (w_rd_grant[p]) begin
                w_rd_sel.addr     = bus.port_addr[p*32 +: 32];
                w_rd_sel.size     = bus.port_size[p*2 +: 2];
                w_rd_sel.uncached = bus.port_uncached[p];
                w_rd_sel.id       = 4'(p);
            end
            if (w_wr_grant[p]) begin
                w_wr_sel.addr     = bus.port_addr[p*32 +: 32];
                w_wr_sel.wdata    = bus.port_wdata[p*32 +: 32];
                w_wr_sel.size     = bus.port_size[p*2 +: 2];
                w_wr_sel.uncached = bus.port_uncached[p];
                w_wr_sel.id       = 4'(p);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.arvalid <= 1'b0;  bus.araddr  <= '0;  bus.arid    <= '0;  bus.arsize <= '0;
            bus.arlen   <= '0;    bus.arburst <= '0;  bus.arcache <= '0;  bus.arprot <= '0;
            bus.arlock  <= '0;
        end else if (w_rd_go) begin
            bus.arvalid <= 1'b1;
            bus.araddr  <= w_rd_sel.addr;
            bus.arid    <= w_rd_sel.id;
            bus.arsize  <= {1'b0, w_rd_sel.size};
            bus.arlen   <= c_len_single;
            bus.arburst <= c_burst_incr;
            bus.arcache <= w_rd_sel.uncached ? c_cache_uncached : c_cache_cached;
            bus.arprot  <= c_prot_default;
            bus.arlock  <= c_lock_normal;
        end else if (bus.arready) begin
            bus.arvalid <= 1'b0;
        end
    end

    // AW and W are loaded together so a write is a single slot
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.awvalid <= 1'b0;  bus.awaddr  <= '0;  bus.awid    <= '0;  bus.awsize <= '0;
            bus.awlen   <= '0;    bus.awburst <= '0;  bus.awcache <= '0;  bus.awprot <= '0;
            bus.awlock  <= '0;    bus.wvalid  <= 1'b0; bus.wid    <= '0;  bus.wdata  <= '0;
            bus.wstrb   <= '0;    bus.wlast   <= 1'b0;
        end else if (w_wr_go) begin
            bus.awvalid <= 1'b1;
            bus.awaddr  <= w_wr_sel.addr;
            bus.awid    <= w_wr_sel.id;
            bus.awsize  <= {1'b0, w_wr_sel.size};
            bus.awlen   <= c_len_single;
            bus.awburst <= c_burst_incr;
            bus.awcache <= w_wr_sel.uncached ? c_cache_uncached : c_cache_cached;
            bus.awprot  <= c_prot_default;
            bus.awlock  <= c_lock_normal;
            bus.wvalid  <= 1'b1;
            bus.wid     <= w_wr_sel.id;
            bus.wdata   <= w_wr_sel.wdata;
            bus.wstrb   <= f_wstrb(w_wr_sel.size, w_wr_sel.addr[1:0]);
            bus.wlast   <= 1'b1;
        end else begin
            if (bus.awready) bus.awvalid <= 1'b0;
            if (bus.wready)  bus.wvalid  <= 1'b0;
        end
    end

`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
    logic r_bus_err;
    logic w_err;

    assign w_err = (bus.rvalid && (bus.rresp != 2'b00 || {1'b0, bus.rid} >= 5'(NPORT))) ||
                   (bus.bvalid && (bus.bresp != 2'b00 || {1'b0, bus.bid} >= 5'(NPORT))) ||
                   (|w_port_err);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_bus_err <= 1'b0;
        else if (w_err)
            r_bus_err <= 1'b1;
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge_mp.sv
`default_nettype none
//==============================================================================
// Module      : tb_sram_axi_bridge_mp
// Description : Directed bench for sram_axi_bridge_mp (NPORT=2, OUTSTANDING=4).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sram_axi_bridge_mp;

    logic clk = 1'b0;
    logic rst_n;
    logic bus_err;
    int   vectors = 0;
    int   miscompares = 0;

    sram_axi_bridge_mp_if #(.NPORT(2)) bus ();

    sram_axi_bridge_mp #(.NPORT(2), .OUTSTANDING(4)) dut (
        .aclk(clk), .aresetn(rst_n), .bus(bus), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.port_req = '0;  bus.port_wr = '0;  bus.port_uncached = '0;
        bus.port_size = '0; bus.port_addr = '0; bus.port_wdata = '0;
        bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
        bus.rvalid = 1'b0;  bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b1;
        bus.bvalid = 1'b0;  bus.bid = '0; bus.bresp = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
        vectors++; if (bus.awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid: got %b want 0", bus.awvalid); end
        vectors++; if (bus.wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid: got %b want 0", bus.wvalid); end
        vectors++; if (bus.araddr !== 32'h0) begin miscompares++; $display("FAIL reset_araddr: got %h want 0", bus.araddr); end
        vectors++; if (bus.wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_wstrb: got %b want 0000", bus.wstrb); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        vectors++; if (bus.port_addr_ok !== 2'b00) begin miscompares++; $display("FAIL reset_addr_ok: got %b want 00", bus.port_addr_ok); end
        vectors++; if (bus.rready !== 1'b1 || bus.bready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got r%b b%b want 1 1", bus.rready, bus.bready); end
    endtask

    task automatic test_read_single();
        do_reset();
        bus.port_req = 2'b01; bus.port_uncached = 2'b01;
        bus.port_size = 4'b0010; bus.port_addr[31:0] = 32'h1FC0_0000;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b01) begin miscompares++; $display("FAIL rd_addr_ok: got %b want 01", bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.port_req = 2'b00;
        vectors++; if (bus.arvalid !== 1'b1) begin miscompares++; $display("FAIL rd_arvalid: got %b want 1", bus.arvalid); end
        vectors++; if (bus.araddr !== 32'h1FC0_0000) begin miscompares++; $display("FAIL rd_araddr: got %h want 1fc00000", bus.araddr); end
        vectors++; if (bus.arid !== 4'd0 || bus.arsize !== 3'd2) begin miscompares++; $display("FAIL rd_id_size: got id %0d size %0d want 0 2", bus.arid, bus.arsize); end
        vectors++; if (bus.arcache !== 4'b0000) begin miscompares++; $display("FAIL rd_arcache: got %b want 0000", bus.arcache); end
        vectors++; if (bus.arlen !== 4'd0 || bus.arburst !== 2'b01) begin miscompares++; $display("FAIL rd_len_burst: got %0d %b want 0 01", bus.arlen, bus.arburst); end
        @(posedge clk); #1;
        vectors++; if (bus.arvalid !== 1'b0) begin miscompares++; $display("FAIL rd_arvalid_drop: got %b want 0", bus.arvalid); end
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b01) begin miscompares++; $display("FAIL rd_data_ok: got %b want 01", bus.port_data_ok); end
        vectors++; if (bus.port_rdata[31:0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_rdata: got %h want deadbeef", bus.port_rdata[31:0]); end
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b00) begin miscompares++; $display("FAIL rd_data_ok_idle: got %b want 00", bus.port_data_ok); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ok;
        do_reset();
        bus.port_req = 2'b11; bus.port_size = 4'b1010;
        bus.port_addr = {32'h0000_2000, 32'h0000_1000};
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_ok = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++; if (bus.port_addr_ok !== exp_ok) begin miscompares++; $display("FAIL rr_addr_ok[%0d]: got %b want %b", i, bus.port_addr_ok, exp_ok); end
            if (i > 0) begin
                vectors++; if (bus.arid !== 4'((i - 1) % 2)) begin miscompares++; $display("FAIL rr_arid[%0d]: got %0d want %0d", i, bus.arid, (i - 1) % 2); end
            end
            if (i == 2) begin
                vectors++; if (bus.araddr !== 32'h0000_2000 || bus.arcache !== 4'hF) begin miscompares++; $display("FAIL rr_addr_cache: got %h %b want 00002000 1111", bus.araddr, bus.arcache); end
            end
            @(posedge clk); #1;
        end
        bus.port_req = 2'b00;
    endtask

    task automatic test_write_byte();
        do_reset();
        bus.port_req = 2'b10; bus.port_wr = 2'b10; bus.port_size = 4'b0000;
        bus.port_addr[63:32] = 32'h8000_0003; bus.port_wdata[63:32] = 32'h0000_00AA;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b10) begin miscompares++; $display("FAIL wr_addr_ok: got %b want 10", bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.port_req = 2'b00;
        vectors++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin miscompares++; $display("FAIL wr_valids: got aw%b w%b want 1 1", bus.awvalid, bus.wvalid); end
        vectors++; if (bus.wstrb !== 4'b1000) begin miscompares++; $display("FAIL wr_wstrb: got %b want 1000", bus.wstrb); end
        vectors++; if (bus.awid !== 4'd1 || bus.wid !== 4'd1) begin miscompares++; $display("FAIL wr_ids: got awid %0d wid %0d want 1 1", bus.awid, bus.wid); end
        vectors++; if (bus.wlast !== 1'b1 || bus.wdata !== 32'h0000_00AA) begin miscompares++; $display("FAIL wr_wdata: got last %b data %h want 1 000000aa", bus.wlast, bus.wdata); end
        vectors++; if (bus.awaddr !== 32'h8000_0003 || bus.awsize !== 3'd0) begin miscompares++; $display("FAIL wr_awaddr: got %h size %0d want 80000003 0", bus.awaddr, bus.awsize); end
        @(posedge clk); #1;
        vectors++; if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin miscompares++; $display("FAIL wr_valid_drop: got aw%b w%b want 0 0", bus.awvalid, bus.wvalid); end
        bus.bvalid = 1'b1; bus.bid = 4'd1;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b10) begin miscompares++; $display("FAIL wr_data_ok: got %b want 10", bus.port_data_ok); end
        @(posedge clk); #1;
        bus.bvalid = 1'b0;
    endtask

    task automatic test_outstanding();
        logic [1:0] exp_ok;
        do_reset();
        bus.port_req = 2'b01; bus.port_size = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_ok = (i < 4) ? 2'b01 : 2'b00;
            vectors++; if (bus.port_addr_ok !== exp_ok) begin miscompares++; $display("FAIL os_addr_ok[%0d]: got %b want %b", i, bus.port_addr_ok, exp_ok); end
            @(posedge clk); #1;
        end
        bus.rvalid = 1'b1; bus.rid = 4'd0;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b01 || bus.port_addr_ok !== 2'b00) begin miscompares++; $display("FAIL os_resp_cycle: got data_ok %b addr_ok %b want 01 00", bus.port_data_ok, bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b01) begin miscompares++; $display("FAIL os_reopen: got %b want 01", bus.port_addr_ok); end
        bus.port_req = 2'b00;
    endtask

    task automatic test_dir_switch();
        do_reset();
        bus.port_req = 2'b01; bus.port_size = 4'b0010; bus.port_addr[31:0] = 32'h0000_0040;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b01) begin miscompares++; $display("FAIL dir_rd_grant: got %b want 01", bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.port_wr = 2'b01;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b00) begin miscompares++; $display("FAIL dir_blocked: got %b want 00", bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.rvalid = 1'b1; bus.rid = 4'd0;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b01 || bus.port_addr_ok !== 2'b00) begin miscompares++; $display("FAIL dir_resp: got data_ok %b addr_ok %b want 01 00", bus.port_data_ok, bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        #1;
        vectors++; if (bus.port_addr_ok !== 2'b01) begin miscompares++; $display("FAIL dir_wr_grant: got %b want 01", bus.port_addr_ok); end
        @(posedge clk); #1;
        bus.port_req = 2'b00;
        vectors++; if (bus.awvalid !== 1'b1 || bus.awid !== 4'd0 || bus.arvalid !== 1'b0) begin miscompares++; $display("FAIL dir_aw: got awvalid %b awid %0d arvalid %b want 1 0 0", bus.awvalid, bus.awid, bus.arvalid); end
    endtask

`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
    task automatic test_checker();
        do_reset();
        bus.port_req = 2'b01; bus.port_size = 4'b0010;
        @(posedge clk); #1;
        bus.port_req = 2'b00;
        @(posedge clk); #1;
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rresp = 2'b10;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b01 || bus_err !== 1'b0) begin miscompares++; $display("FAIL chk_rresp_cycle: got data_ok %b err %b want 01 0", bus.port_data_ok, bus_err); end
        @(posedge clk); #1;
        bus.rvalid = 1'b0; bus.rresp = 2'b00;
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL chk_rresp_set: got %b want 1", bus_err); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL chk_sticky: got %b want 1", bus_err); end
        do_reset();
        bus.rvalid = 1'b1; bus.rid = 4'd7;
        #1;
        vectors++; if (bus.port_data_ok !== 2'b00) begin miscompares++; $display("FAIL chk_rid_drop: got %b want 00", bus.port_data_ok); end
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL chk_rid_err: got %b want 1", bus_err); end
    endtask
`else
    task automatic test_checker();
        do_reset();
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rresp = 2'b10;
        @(posedge clk); #1;
        bus.rvalid = 1'b0; bus.rresp = 2'b00;
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL nochk_bus_err: got %b want 0", bus_err); end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.port_req = 2'b11; bus.port_wr = 2'b10; bus.port_size = 4'b1010;
`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
        bus.rvalid = 1'b1; bus.rid = 4'd7;
`endif
        @(posedge clk); #1;
        bus.rvalid = 1'b0; bus.port_req = 2'b00;
        vectors++; if (bus.arvalid !== 1'b1 || bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got ar%b aw%b w%b want 1 1 1", bus.arvalid, bus.awvalid, bus.wvalid); end
`ifdef SRAM_AXI_BRIDGE_CHECKER_EN
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL ar_pre_err: got %b want 1", bus_err); end
`endif
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin miscompares++; $display("FAIL ar_valids: got ar%b aw%b w%b want 0 0 0", bus.arvalid, bus.awvalid, bus.wvalid); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL ar_bus_err: got %b want 0", bus_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_read_single();
        test_round_robin();
        test_write_byte();
        test_outstanding();
        test_dir_switch();
        test_checker();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
